// File: rtl/arb_pkg.sv
// Shared types and constants for the IFU/LSU AXI-lite arbiter.
// Bus width macros are defined here only when the surrounding build has not already provided them.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_WSTRB_W
`define AXI_WSTRB_W 4
`endif

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_M0 = 2'd1,
    RD_M1 = 2'd2,
    WR_M1 = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: under contention, the master not granted last wins.
module rr_arb2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (last == M1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Arbitrates the read-only IFU (m0) and the read/write LSU (m1) onto one AXI-lite slave,
// keeping at most one transaction outstanding on the slave port.
module axi_lite_arbiter
  import arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // m0: IFU, read-only
  input  logic [`AXI_ADDR_W-1:0]  m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [`AXI_DATA_W-1:0]  m0_rdata,
  output logic [`AXI_RESP_W-1:0]  m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  // m1: LSU
  input  logic [`AXI_ADDR_W-1:0]  m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [`AXI_DATA_W-1:0]  m1_rdata,
  output logic [`AXI_RESP_W-1:0]  m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  input  logic [`AXI_ADDR_W-1:0]  m1_awaddr,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [`AXI_DATA_W-1:0]  m1_wdata,
  input  logic [`AXI_WSTRB_W-1:0] m1_wstrb,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [`AXI_RESP_W-1:0]  m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  // shared slave
  output logic [`AXI_ADDR_W-1:0]  s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [`AXI_DATA_W-1:0]  s_rdata,
  input  logic [`AXI_RESP_W-1:0]  s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic [`AXI_ADDR_W-1:0]  s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [`AXI_DATA_W-1:0]  s_wdata,
  output logic [`AXI_WSTRB_W-1:0] s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [`AXI_RESP_W-1:0]  s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       last_q, last_d;

  logic       req0, req1r, req1w;
  logic [1:0] rr_gnt, gnt;

  assign req0  = m0_arvalid;
  assign req1r = m1_arvalid;
  assign req1w = m1_awvalid & m1_wvalid;

  rr_arb2 u_rr_arb2 (
    .req  ({req1r | req1w, req0}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // Fixed-priority mode lets m1 (LSU) win every contention.
  assign gnt = (RR_EN != 0) ? rr_gnt
                            : ((req1r | req1w) ? 2'b10 : {1'b0, req0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      last_q    <= M1;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ar_done_d  = ar_done_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    last_d     = last_q;

    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (gnt[1]) begin
          last_d  = M1;
          state_d = req1w ? WR_M1 : RD_M1;
        end else if (gnt[0]) begin
          last_d  = M0;
          state_d = RD_M0;
        end
      end

      RD_M0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~ar_done_q;
        m0_arready = s_arready & ~ar_done_q;
        if (m0_arvalid && s_arready && !ar_done_q) ar_done_d = 1'b1;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready) state_d = IDLE;
      end

      RD_M1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~ar_done_q;
        m1_arready = s_arready & ~ar_done_q;
        if (m1_arvalid && s_arready && !ar_done_q) ar_done_d = 1'b1;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready) state_d = IDLE;
      end

      WR_M1: begin
        // AW and W complete independently; each is masked once it has handshaken.
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done_q;
        m1_awready = s_awready & ~aw_done_q;
        if (m1_awvalid && s_awready && !aw_done_q) aw_done_d = 1'b1;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done_q;
        m1_wready  = s_wready & ~w_done_q;
        if (m1_wvalid && s_wready && !w_done_q) w_done_d = 1'b1;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
        if (s_bvalid && m1_bready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: the slave side is driven by hand step by step.
module tb_axi_lite_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [3:0]  m1_wstrb, s_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  int checks = 0;
  int failures = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int aw_base, w_base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_awvalid && s_awready) aw_hs <= aw_hs + 1;
    if (s_wvalid && s_wready)   w_hs  <= w_hs + 1;
  end

  axi_lite_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0;
    m1_bready = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;

    // reset: requests and slave responses present, every handshake output must stay low
    m0_arvalid = 1'b1; m0_rready = 1'b1; s_rvalid = 1'b1; s_arready = 1'b1;
    #12;
    chk1("rst_s_arvalid", s_arvalid, 1'b0);
    chk1("rst_m0_arready", m0_arready, 1'b0);
    chk1("rst_s_rready", s_rready, 1'b0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    m0_arvalid = 1'b0; s_rvalid = 1'b0; s_arready = 1'b0;
    rst_n = 1'b1;
    tick;

    // contention straight after reset: m0 first
    m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1;
    m1_araddr = 32'h0000_0200; m1_arvalid = 1'b1; m1_rready = 1'b1;
    #1 chk1("c_idle_arvalid", s_arvalid, 1'b0);
    tick;
    chk1("c1_arvalid", s_arvalid, 1'b1);
    chk("c1_m0_first", s_araddr, 32'h0000_0100);
    s_arready = 1'b1;
    #1 chk1("c1_m0_arready", m0_arready, 1'b1);
    chk1("c1_m1_arready", m1_arready, 1'b0);
    tick;
    s_arready = 1'b0; m0_araddr = 32'h0000_0104;
    s_rvalid = 1'b1; s_rdata = 32'h0000_00A0;
    #1 chk1("c1_ar_done", s_arvalid, 1'b0);
    chk("c1_m0_rdata", m0_rdata, 32'h0000_00A0);
    chk1("c1_m1_rvalid", m1_rvalid, 1'b0);
    tick;
    s_rvalid = 1'b0; s_rdata = '0;
    #1 chk1("c1_idle_arvalid", s_arvalid, 1'b0);
    // repeated contention: m0 was granted last, so m1 wins
    tick;
    chk("c2_m1_first", s_araddr, 32'h0000_0200);
    s_arready = 1'b1;
    tick;
    s_arready = 1'b0; m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_00B1;
    #1 chk("c2_m1_rdata", m1_rdata, 32'h0000_00B1);
    chk1("c2_m0_rvalid", m0_rvalid, 1'b0);
    tick;
    s_rvalid = 1'b0; s_rdata = '0;
    tick;
    chk("c2_m0_second", s_araddr, 32'h0000_0104);
    s_arready = 1'b1;
    tick;
    s_arready = 1'b0; m0_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_00C2;
    #1 chk("c2_m0_rdata", m0_rdata, 32'h0000_00C2);
    tick;
    s_rvalid = 1'b0; s_rdata = '0;
    #1;

    // lone m0 read, slave answers 3 cycles after the AR handshake
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    #1;
    tick;
    chk1("r0_arvalid", s_arvalid, 1'b1);
    chk("r0_araddr", s_araddr, 32'h8000_0000);
    s_arready = 1'b1;
    #1 chk1("r0_arready", m0_arready, 1'b1);
    tick;
    s_arready = 1'b0; m0_arvalid = 1'b0;
    tick;
    tick;
    s_rvalid = 1'b1; s_rdata = 32'h0000_0013; s_rresp = 2'd0;
    #1 chk1("r0_rvalid", m0_rvalid, 1'b1);
    chk("r0_rdata", m0_rdata, 32'h0000_0013);
    chk("r0_rresp", 32'(m0_rresp), 32'd0);
    chk1("r0_s_rready", s_rready, 1'b1);
    chk1("r0_m1_rvalid", m1_rvalid, 1'b0);
    chk("r0_m1_rdata", m1_rdata, 32'h0);
    chk1("r0_m1_arready", m1_arready, 1'b0);
    tick;
    s_rvalid = 1'b0; s_rdata = '0;
    #1 chk1("r0_back_idle", m0_rvalid, 1'b0);

    // m1 write, W accepted two cycles after AW
    m1_awaddr = 32'h8000_0100; m1_awvalid = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wvalid = 1'b1; m1_bready = 1'b1;
    #1 chk1("w_idle_awvalid", s_awvalid, 1'b0);
    tick;
    aw_base = aw_hs; w_base = w_hs;
    chk1("w_awvalid", s_awvalid, 1'b1);
    chk("w_awaddr", s_awaddr, 32'h8000_0100);
    chk1("w_wvalid", s_wvalid, 1'b1);
    chk("w_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("w_wstrb", 32'(s_wstrb), 32'hF);
    s_awready = 1'b1;
    #1 chk1("w_m1_awready", m1_awready, 1'b1);
    chk1("w_m1_wready_early", m1_wready, 1'b0);
    tick;
    s_awready = 1'b0;
    #1 chk1("w_aw_done", s_awvalid, 1'b0);
    chk1("w_wvalid_hold", s_wvalid, 1'b1);
    tick;
    s_wready = 1'b1; s_awready = 1'b1;
    #1 chk1("w_m1_wready", m1_wready, 1'b1);
    chk1("w_aw_masked", m1_awready, 1'b0);
    tick;
    s_wready = 1'b0; s_awready = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd0;
    #1 chk1("w_bvalid", m1_bvalid, 1'b1);
    chk("w_bresp", 32'(m1_bresp), 32'd0);
    chk1("w_s_bready", s_bready, 1'b1);
    tick;
    s_bvalid = 1'b0;
    #1 chk("w_aw_count", 32'(aw_hs - aw_base), 32'd1);
    chk("w_w_count", 32'(w_hs - w_base), 32'd1);
    chk1("w_back_idle", m1_bvalid, 1'b0);

    // m1 write and read together: write first, then read with SLVERR
    m1_awaddr = 32'h8000_0200; m1_awvalid = 1'b1; m1_wdata = 32'h0000_1234; m1_wvalid = 1'b1;
    m1_araddr = 32'h0000_0300; m1_arvalid = 1'b1;
    #1;
    tick;
    chk1("wr_awvalid", s_awvalid, 1'b1);
    chk1("wr_no_arvalid", s_arvalid, 1'b0);
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    tick;
    s_awready = 1'b0; s_wready = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd3;
    #1 chk("wr_bresp_decerr", 32'(m1_bresp), 32'd3);
    chk1("wr_arvalid_during_b", s_arvalid, 1'b0);
    tick;
    s_bvalid = 1'b0; s_bresp = 2'd0;
    #1 chk1("wr_idle_arvalid", s_arvalid, 1'b0);
    tick;
    chk1("wr_rd_arvalid", s_arvalid, 1'b1);
    chk("wr_rd_araddr", s_araddr, 32'h0000_0300);
    s_arready = 1'b1;
    #1;
    tick;
    s_arready = 1'b0; m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rresp = 2'd2; s_rdata = 32'h0000_0055;
    #1 chk("wr_rresp_slverr", 32'(m1_rresp), 32'd2);
    chk("wr_rdata", m1_rdata, 32'h0000_0055);
    tick;
    s_rvalid = 1'b0; s_rresp = 2'd0; s_rdata = '0;
    #1;

    // stray slave responses while idle are ignored
    s_rvalid = 1'b1; s_bvalid = 1'b1; s_rdata = 32'h0000_FFFF;
    #1 chk1("stray_s_rready", s_rready, 1'b0);
    chk1("stray_s_bready", s_bready, 1'b0);
    chk1("stray_m0_rvalid", m0_rvalid, 1'b0);
    chk1("stray_m1_rvalid", m1_rvalid, 1'b0);
    chk1("stray_m1_bvalid", m1_bvalid, 1'b0);
    chk("stray_m0_rdata", m0_rdata, 32'h0);
    tick;
    chk1("stray_still_idle", s_rready, 1'b0);
    s_rvalid = 1'b0; s_bvalid = 1'b0; s_rdata = '0;
    #1;

    // reset while RD_M1 waits for its data
    m1_araddr = 32'h0000_0400; m1_arvalid = 1'b1;
    #1;
    tick;
    s_arready = 1'b1;
    #1;
    tick;
    s_arready = 1'b0; m1_arvalid = 1'b0;
    #1 chk1("rr_pre_rready", s_rready, 1'b1);
    #2 rst_n = 1'b0; s_rvalid = 1'b1;
    #1 chk1("rr_rst_rready", s_rready, 1'b0);
    chk1("rr_rst_m1_rvalid", m1_rvalid, 1'b0);
    chk1("rr_rst_arvalid", s_arvalid, 1'b0);
    s_rvalid = 1'b0;
    #3 rst_n = 1'b1;
    tick;
    chk1("rr_post_idle", s_rready, 1'b0);
    m0_araddr = 32'h0000_0500; m0_arvalid = 1'b1;
    #1;
    tick;
    chk("rr_m0_araddr", s_araddr, 32'h0000_0500);
    s_arready = 1'b1;
    #1;
    tick;
    s_arready = 1'b0; m0_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_0077;
    #1 chk("rr_m0_rdata", m0_rdata, 32'h0000_0077);
    chk1("rr_m1_rvalid", m1_rvalid, 1'b0);
    tick;
    s_rvalid = 1'b0; s_rdata = '0;
    #1 chk1("rr_end_idle", m0_rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
